qq_host_port: RTL

//  Initiator side of the QuickQ enq/deq interface: drives enq/deq/din into the queue control node, collects dout.

---
 rtl/qq_pkg.sv | 26 ++
 rtl/qq_occ_counter.sv | 41 ++++
 rtl/qq_host_port.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/qq_pkg.sv
// Shared types for the QuickQ host port: command ops, response status and FSM states.
package qq_pkg;

  localparam int KW_DEFAULT = 16;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ENQ = 2'd1,
    OP_DEQ = 2'd2,
    OP_CLR = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_OK    = 2'd0,
    ST_FULL  = 2'd1,
    ST_EMPTY = 2'd2
  } status_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } host_state_t;

endpackage

// File: rtl/qq_occ_counter.sv
// Local occupancy tracker for the QuickQ host port: up/down/clear counter with full/empty flags.
module qq_occ_counter #(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       inc_i,
  input  logic                       dec_i,
  input  logic                       clr_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0] count_q, count_d;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // NOTE: count_d gets a default first so every path assigns it and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clr_i)                  count_d = '0;
    else if (inc_i && !full_o)  count_d = count_q + 1'b1;
    else if (dec_i && !empty_o) count_d = count_q - 1'b1;
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  // The host FSM rejects ENQ-when-full and DEQ-when-empty, so these must never fire.
  assert property (@(posedge clk) disable iff (!rst) !(inc_i && full_o));
  assert property (@(posedge clk) disable iff (!rst) !(dec_i && empty_o));

endmodule

// File: rtl/qq_host_port.sv
// QuickQ host port: command/response streams in front of the enq/deq queue interface.
// Optional statistics counters are enabled with `define QQ_HOST_STATS_EN.
module qq_host_port
  import qq_pkg::*;
#(
  parameter int KW      = KW_DEFAULT,
  parameter int DEPTH   = 16,
  parameter int DEQ_LAT = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [KW-1:0]              cmd_key,
  output logic                       q_enq,
  output logic                       q_deq,
  output logic [KW-1:0]              q_din,
  input  logic [KW-1:0]              q_dout,
  input  logic                       q_busy,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [KW-1:0]              rsp_key,
  output logic [1:0]                 rsp_status,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
`ifdef QQ_HOST_STATS_EN
  ,
  output logic [31:0]                stat_enq,
  output logic [31:0]                stat_deq,
  output logic [31:0]                stat_rej
`endif
);

  host_state_t   state_q, state_d;
  op_t           op_q, op_d;
  op_t           cmd_op_e;
  logic [KW-1:0] key_q, key_d;
  logic [KW-1:0] rsp_key_q, rsp_key_d;
  status_t       status_q, status_d;
  logic [2:0]    lat_q, lat_d;
  logic          clr;

  assign cmd_op_e = op_t'(cmd_op);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    key_d     = key_q;
    rsp_key_d = rsp_key_q;
    status_d  = status_q;
    lat_d     = lat_q;
    q_enq     = 1'b0;
    q_deq     = 1'b0;
    clr       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d      = cmd_op_e;
          key_d     = cmd_key;
          rsp_key_d = '0;
          status_d  = ST_OK;
          state_d   = S_RESP;
          case (cmd_op_e)
            OP_CLR: clr = 1'b1;
            OP_ENQ: if (full)  status_d = ST_FULL;  else state_d = S_ISSUE;
            OP_DEQ: if (empty) status_d = ST_EMPTY; else state_d = S_ISSUE;
            default: ;
          endcase
        end
      end
      // Strobes are combinational so they land in the first cycle q_busy is low.
      S_ISSUE: begin
        if (!q_busy) begin
          if (op_q == OP_ENQ) begin
            q_enq   = 1'b1;
            state_d = S_RESP;
          end else begin
            q_deq   = 1'b1;
            lat_d   = 3'(DEQ_LAT - 1);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (lat_q == 3'd0) begin
          rsp_key_d = q_dout;
          state_d   = S_RESP;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_key_d = '0;
          status_d  = ST_OK;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      op_q      <= OP_NOP;
      key_q     <= '0;
      rsp_key_q <= '0;
      status_q  <= ST_OK;
      lat_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      key_q     <= key_d;
      rsp_key_q <= rsp_key_d;
      status_q  <= status_d;
      lat_q     <= lat_d;
    end
  end

  // Gating with rst keeps cmd_ready low while reset is held.
  assign cmd_ready  = (state_q == S_IDLE) && rst;
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_key    = rsp_key_q;
  assign rsp_status = status_q;
  assign q_din      = q_enq ? key_q : '0;

  qq_occ_counter #(
    .DEPTH (DEPTH)
  ) u_occ (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (q_enq),
    .dec_i   (q_deq),
    .clr_i   (clr),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  assert property (@(posedge clk) disable iff (!rst) !(q_enq && q_deq));
  assert property (@(posedge clk) disable iff (!rst) !((q_enq || q_deq) && q_busy));

`ifdef QQ_HOST_STATS_EN
  logic [31:0] stat_enq_q, stat_deq_q, stat_rej_q;
  logic        rej;

  assign rej = cmd_valid && cmd_ready &&
               (((cmd_op_e == OP_ENQ) && full) || ((cmd_op_e == OP_DEQ) && empty));

  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_enq_q <= '0;
      stat_deq_q <= '0;
      stat_rej_q <= '0;
    end else begin
      if (q_enq && (stat_enq_q != '1)) stat_enq_q <= stat_enq_q + 32'd1;
      if (q_deq && (stat_deq_q != '1)) stat_deq_q <= stat_deq_q + 32'd1;
      if (rej   && (stat_rej_q != '1)) stat_rej_q <= stat_rej_q + 32'd1;
    end
  end

  assign stat_enq = stat_enq_q;
  assign stat_deq = stat_deq_q;
  assign stat_rej = stat_rej_q;
`endif

endmodule
